// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES ciphertext output path.
package aes_pkg;

  localparam int unsigned AES_BLK_W = 128;

  typedef logic [AES_BLK_W-1:0] aes_block_t;

  // Output FSM states of the serializer
  typedef enum logic [0:0] {
    StIdle,
    StSend
  } ser_state_e;

  // Number of WORD_W-bit words in one AES block
  function automatic int unsigned nwords(input int unsigned word_w);
    return AES_BLK_W / word_w;
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Block FIFO: DEPTH entries of one AES block each, with level count.
// Caller guarantees pop only when non-empty and push only when not full or popping.
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  aes_block_t               wr_data,
  input  logic                     pop,
  output aes_block_t               head,
  output aes_block_t               head_next,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  aes_block_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_nxt;

  // Storage write; no reset needed since level gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end

  // Head and the entry behind it, used to present the next block without a bubble
  always_comb begin
    rd_ptr_nxt = rd_ptr + 1'b1;
    head       = mem[rd_ptr];
    head_next  = mem[rd_ptr_nxt];
    full       = (level == LW'(DEPTH));
  end

endmodule

// File: rtl/aes_ct_serializer.sv
// AES ciphertext serializer: captures 128-bit blocks on the core's done edge,
// buffers them and streams WORD_W-bit words MSW first over valid/ready.
// Optional per-byte even parity output m_par when AES_SER_PARITY_EN is defined.
module aes_ct_serializer
  import aes_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  aes_block_t               ct_i,
  input  logic                     done_i,
  input  logic                     clr_ovf,
  output logic [WORD_W-1:0]        m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   blk_level
`ifdef AES_SER_PARITY_EN
  ,
  output logic [WORD_W/8-1:0]      m_par
`endif
);

  localparam int unsigned NW = nwords(WORD_W);
  localparam int unsigned KW = $clog2(NW);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  ser_state_e  state_q;
  logic [KW-1:0] k_q;
  logic [KW-1:0] k_d;
  logic        done_q;
  logic        cap;
  logic        xfer;
  logic        pop;
  logic        push;
  logic        drop;
  logic        fifo_full;
  aes_block_t  head;
  aes_block_t  head_next;
  aes_block_t  nxt_blk;
  aes_block_t  nxt_shift;
  logic [LW-1:0] level_nxt;
  logic        valid_d;
  logic        last_d;
  logic [WORD_W-1:0] word_d;
`ifdef AES_SER_PARITY_EN
  logic [WORD_W/8-1:0] par_d;
`endif

  aes_blk_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .wr_data   (ct_i),
    .pop       (pop),
    .head      (head),
    .head_next (head_next),
    .full      (fifo_full),
    .level     (blk_level)
  );

  // Capture/pop decisions and the word to present after this edge
  always_comb begin
    cap  = done_i & ~done_q;
    xfer = m_valid & m_ready;
    pop  = xfer & m_last;
    // A final-word pop frees a slot in the same cycle as the capture
    push = cap & (~fifo_full | pop);
    drop = cap & fifo_full & ~pop;
    level_nxt = blk_level + LW'(push) - LW'(pop);
    valid_d   = (level_nxt != '0);

    // Block at the FIFO head after this edge; ct_i bypasses when it lands in an empty FIFO
    if (pop) begin
      nxt_blk = (blk_level > LW'(1)) ? head_next : ct_i;
    end else begin
      nxt_blk = (blk_level != '0) ? head : ct_i;
    end

    if (pop) begin
      k_d = '0;
    end else if (xfer) begin
      k_d = k_q + 1'b1;
    end else begin
      k_d = k_q;
    end

    nxt_shift = nxt_blk << (int'(k_d) * WORD_W);
    word_d    = nxt_shift[AES_BLK_W-1 -: WORD_W];
    last_d    = (k_d == KW'(NW - 1));
`ifdef AES_SER_PARITY_EN
    for (int i = 0; i < int'(WORD_W / 8); i++) begin
      par_d[i] = ^word_d[8*i +: 8];
    end
`endif
  end

  // Output FSM with registered stream outputs; outputs only change on load or transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
`ifdef AES_SER_PARITY_EN
      m_par   <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid_d) begin
            state_q <= StSend;
            k_q     <= k_d;
            m_valid <= 1'b1;
            m_data  <= word_d;
            m_last  <= last_d;
`ifdef AES_SER_PARITY_EN
            m_par   <= par_d;
`endif
          end
        end
        StSend: begin
          if (xfer) begin
            if (valid_d) begin
              k_q     <= k_d;
              m_data  <= word_d;
              m_last  <= last_d;
`ifdef AES_SER_PARITY_EN
              m_par   <= par_d;
`endif
            end else begin
              state_q <= StIdle;
              k_q     <= '0;
              m_valid <= 1'b0;
              m_data  <= '0;
              m_last  <= 1'b0;
`ifdef AES_SER_PARITY_EN
              m_par   <= '0;
`endif
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Done edge detect and sticky overflow; a new drop beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done_q <= done_i;
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_ct_serializer.sv
// Self-checking bench for aes_ct_serializer: directed scenarios plus random
// traffic, checked against a block-queue reference model.
module tb_aes_ct_serializer;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned NW    = 128 / W;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [127:0]  ct_i;
  logic          done_i;
  logic          clr_ovf;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          overflow;
  logic [LW-1:0] blk_level;
`ifdef AES_SER_PARITY_EN
  logic [W/8-1:0] m_par;
`endif

  aes_ct_serializer #(
    .WORD_W (W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ct_i      (ct_i),
    .done_i    (done_i),
    .clr_ovf   (clr_ovf),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .overflow  (overflow),
    .blk_level (blk_level)
`ifdef AES_SER_PARITY_EN
    ,
    .m_par     (m_par)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue of stored blocks, word index into the head, sticky flag
  logic [127:0] q[$];
  int           k;
  bit           ovf;
  bit           pd;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    k   = 0;
    ovf = 1'b0;
    pd  = 1'b0;
  endtask

  task automatic compare_outputs();
    logic [127:0] blk;
    logic [W-1:0] ew;
    bit           ev;
    ev = (q.size() > 0);
    ew = '0;
    if (ev) begin
      blk = q[0];
      ew  = blk[127 - k*W -: W];
    end
    check_eq("m_valid", m_valid, ev);
    check_eq("m_data", m_data, ew);
    check_eq("m_last", m_last, ev && (k == NW - 1));
    check_eq("blk_level", blk_level, q.size());
    check_eq("overflow", overflow, ovf);
`ifdef AES_SER_PARITY_EN
    begin
      logic [W/8-1:0] ep;
      for (int i = 0; i < W/8; i++) ep[i] = ^ew[8*i +: 8];
      check_eq("m_par", m_par, ep);
    end
`endif
  endtask

  // One clock: drive inputs, advance the model across the edge, then compare
  task automatic step(input logic d, input logic [127:0] c, input logic r, input logic cl);
    bit xfer;
    bit cap;
    bit drop;
    @(negedge clk);
    done_i  = d;
    ct_i    = c;
    m_ready = r;
    clr_ovf = cl;
    @(posedge clk);
    xfer = (q.size() > 0) && r;
    if (xfer) begin
      if (k == NW - 1) begin
        void'(q.pop_front());
        k = 0;
      end else begin
        k++;
      end
    end
    cap  = d && !pd;
    pd   = d;
    drop = 1'b0;
    if (cap) begin
      if (q.size() < DEPTH) q.push_back(c);
      else drop = 1'b1;
    end
    if (drop) ovf = 1'b1;
    else if (cl) ovf = 1'b0;
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) step(1'b0, '0, r, 1'b0);
  endtask

  function automatic logic [127:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] t1;
    logic [31:0]  t1w [4];
    logic [127:0] ba, bb, bc, bd, be, bf;

    t1 = 128'h3925841d02dc09fbdc118597196a0b32;
    t1w = '{32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32};

    rst_n = 1'b0; done_i = 1'b0; ct_i = '0; m_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    #3;
    check_eq("rst_valid", m_valid, 1'b0);
    check_eq("rst_data", m_data, '0);
    check_eq("rst_last", m_last, 1'b0);
    check_eq("rst_level", blk_level, '0);
    check_eq("rst_ovf", overflow, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, 1'b1);

    // Single block, consumer always ready
    step(1'b1, t1, 1'b1, 1'b0);
    check_eq("t1_valid", m_valid, 1'b1);
    check_eq("t1_w0", m_data, t1w[0]);
    for (int i = 1; i < 4; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      check_eq("t1_word", m_data, t1w[i]);
    end
    check_eq("t1_last", m_last, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    check_eq("t1_done", m_valid, 1'b0);

    // Back-pressure with ready pattern 1,0,0,1,...
    step(1'b1, t1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, '0, (i % 3) == 2, 1'b0);
    idle(2, 1'b1);

    // Overflow: three captures into a stalled two-deep FIFO
    ba = rnd_blk(); bb = rnd_blk(); bc = rnd_blk();
    step(1'b1, ba, 1'b0, 1'b0); step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, bb, 1'b0, 1'b0); step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, bc, 1'b0, 1'b0); step(1'b0, '0, 1'b0, 1'b0);
    check_eq("t3_level", blk_level, 2);
    check_eq("t3_ovf", overflow, 1'b1);
    idle(10, 1'b1);
    check_eq("t3_drained", blk_level, 0);
    step(1'b0, '0, 1'b1, 1'b1);
    check_eq("t3_clr", overflow, 1'b0);

    // Capture coincides with the final-word pop of a full FIFO
    ba = rnd_blk(); bb = rnd_blk(); bd = rnd_blk();
    step(1'b1, ba, 1'b0, 1'b0); step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, bb, 1'b0, 1'b0); step(1'b0, '0, 1'b0, 1'b0);
    idle(3, 1'b1);
    step(1'b1, bd, 1'b1, 1'b0);
    check_eq("t4_ovf", overflow, 1'b0);
    check_eq("t4_level", blk_level, 2);
    check_eq("t4_nobubble", m_valid, 1'b1);
    check_eq("t4_next_w0", m_data, bb[127 -: 32]);
    idle(10, 1'b1);

    // Reset mid-stream after the first word is taken
    be = rnd_blk(); bf = rnd_blk();
    step(1'b1, be, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_valid", m_valid, 1'b0);
    check_eq("t5_level", blk_level, '0);
    check_eq("t5_data", m_data, '0);
    model_reset();
    done_i = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, bf, 1'b1, 1'b0);
    check_eq("t5_restart_w0", m_data, bf[127 -: 32]);
    idle(6, 1'b1);

    // done_i held for three cycles captures a single block
    ba = rnd_blk();
    repeat (3) step(1'b1, ba, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check_eq("t6_level", blk_level, 1);
    idle(6, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) == 0, rnd_blk(), $urandom_range(0, 9) < 6,
           $urandom_range(0, 15) == 0);
    end
    idle(12, 1'b1);
    check_eq("end_empty", blk_level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
